cpm_egress_fifo: RTL and testbench
==================================

Name: cpm_egress_fifo

Overview:
- Elastic buffer directly downstream of the CPM packet modifier. Consumes the modifier's output valid/ready stream: id[3:0], opcode[3:0], payload[15:0].
- Stores up to DEPTH packets and re-presents them, in order, on a registered valid/ready output that stays stable under stall.
- Decouples the CPM output from sink back-pressure, so a stalling sink does not hold the modifier's output stage.
- Reports current occupancy for the bench and the register map.

Parameters:
DEPTH, 4, number of packet entries; power of two, minimum 2
CW, $clog2(DEPTH+1), occupancy counter width (derived; do not override)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-low reset; asserted when 0
in_valid  in  1  upstream packet valid (from CPM out_valid)
in_ready  out  1  FIFO can accept (to CPM out_ready)
in_id  in  4  packet id
in_opcode  in  4  packet opcode
in_payload  in  16  packet payload
out_valid  out  1  head packet valid
out_ready  in  1  sink accepts head
out_id  out  4  head id
out_opcode  out  4  head opcode
out_payload  out  16  head payload
occupancy  out  CW  entries currently stored
stats_clr  in  1  synchronous clear of statistics counters
stat_pkt_cnt  out  32  packets delivered (out fires)
stat_hwm  out  CW  occupancy high-water mark
stat_stall_cyc  out  16  cycles with out_valid=1 and out_ready=0

Behaviour:
- Handshakes: push = in_valid && in_ready; pop = out_valid && out_ready.
- Reset (rst=0, asynchronous): wr_ptr=rd_ptr=0, occupancy=0, out_valid=0, in_ready=1, out_id/out_opcode/out_payload=0, all stats=0. Storage array is not reset.
- in_ready = (occupancy != DEPTH), derived from registered state only. It does not depend combinationally on out_ready, so there is no full-pass-through.
- out_valid = (occupancy != 0). out_* are driven from the registered head entry.
- Latency: a packet pushed into an empty FIFO at edge N appears with out_valid=1 after edge N, i.e. one cycle later. No same-cycle bypass.
- Pointer wrap: wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- Occupancy update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged; write and read both proceed, including when occupancy==1.
- Full (occupancy==DEPTH): in_ready=0, no write. A pop in this cycle frees a slot; in_ready rises the next cycle.
- Empty: out_valid=0. out_* hold their last value and sinks must not sample them.
- Stall stability: while out_valid=1 && out_ready=0, out_id/out_opcode/out_payload/out_valid stay unchanged next cycle. out_valid never drops without a pop.
- Ordering is strictly FIFO. No field is modified, and packets are never dropped or duplicated.
- Reset mid-operation: all entries are discarded immediately. After reset release, out_valid=0 until a new push.
- Stats (see Optional Feature):
  - stat_pkt_cnt increments on each pop and wraps at 2^32.
  - stat_hwm = max(stat_hwm, next occupancy) every cycle.
  - stat_stall_cyc saturates at 16'hFFFF.
  - stats_clr=1 zeroes all three counters at the next edge; a clear has priority over a same-cycle increment.

Optional Feature:
- Macro: CPM_EGRESS_STATS_EN.
- Defined: statistics counters implemented as described above.
- Undefined: counters not instantiated. stat_pkt_cnt, stat_hwm and stat_stall_cyc are tied to 0, and stats_clr is ignored.
- Port list is identical in both builds. FIFO behaviour is identical in both builds.

Test Plan:
- Reset, then push id=3 opcode=5 payload=16'hBEEF with out_ready=1 -> out_valid rises one cycle after the push; same fields delivered; occupancy returns to 0; stat_pkt_cnt=1.
- out_ready=0, push 5 packets (payload 1..5) back-to-back, DEPTH=4 -> first 4 accepted; in_ready=0 with occupancy=4; 5th held; out_* stable at payload 1 every cycle; stat_hwm=4.
- From full, raise out_ready -> payloads 1,2,3,4,5 delivered in order with no gaps or duplicates; in_ready rises the cycle after the first pop.
- Occupancy=1, simultaneous push and pop for 20 cycles with incrementing payloads -> occupancy stays 1; output sequence equals input sequence delayed by one.
- Hold out_valid=1/out_ready=0 for 70000 cycles (stats build) -> stat_stall_cyc=16'hFFFF, no wrap; stats_clr pulse -> all stats read 0 next cycle.
- Assert rst=0 asynchronously with occupancy=3 -> out_valid=0, in_ready=1, occupancy=0 without waiting for a clock edge; no stale packet delivered after release.

Source files
------------

// File: rtl/cpm_egress_fifo.sv
// ============================================================================
// cpm_egress_fifo
// ----------------------------------------------------------------------------
// Elastic buffer placed directly after the CPM packet modifier. Packets
// (id, opcode, payload) are accepted on a valid/ready input, stored in order
// in a DEPTH-entry ring, and presented on a registered valid/ready output that
// stays stable while the sink stalls. in_ready depends only on registered
// state, so sink back-pressure never reaches the modifier combinationally.
//
// Optional feature macro: CPM_EGRESS_STATS_EN
//   defined   -> statistics counters (packets delivered, occupancy high-water
//                mark, stall cycles) are implemented, cleared by stats_clr.
//   undefined -> statistics outputs are tied to 0 and stats_clr is ignored.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-low reset
//   in_valid       upstream packet valid
//   in_ready       FIFO can accept a packet (registered)
//   in_id          packet id
//   in_opcode      packet opcode
//   in_payload     packet payload
//   out_valid      head packet valid (registered)
//   out_ready      sink accepts head packet
//   out_id         head id (registered)
//   out_opcode     head opcode (registered)
//   out_payload    head payload (registered)
//   occupancy      number of stored packets
//   stats_clr      synchronous clear of the statistics counters
//   stat_pkt_cnt   packets delivered, wraps at 2^32
//   stat_hwm       occupancy high-water mark
//   stat_stall_cyc cycles with out_valid=1 and out_ready=0, saturating
// ============================================================================
module cpm_egress_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_id,
    input  logic [3:0]    in_opcode,
    input  logic [15:0]   in_payload,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_id,
    output logic [3:0]    out_opcode,
    output logic [15:0]   out_payload,
    output logic [CW-1:0] occupancy,
    input  logic          stats_clr,
    output logic [31:0]   stat_pkt_cnt,
    output logic [CW-1:0] stat_hwm,
    output logic [15:0]   stat_stall_cyc
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 24;

    // Storage and pointers
    logic [EW-1:0]   mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   occ_r;
    logic            out_valid_r;
    logic            in_ready_r;
    logic [EW-1:0]   head_r;

    // Next-state signals
    logic            push_s;
    logic            pop_s;
    logic [CW-1:0]   occ_nxt_s;
    logic [AW-1:0]   wr_nxt_s;
    logic [AW-1:0]   rd_nxt_s;
    logic            head_load_s;
    logic [EW-1:0]   head_nxt_s;
    logic [EW-1:0]   in_entry_s;

    assign in_entry_s = {in_id, in_opcode, in_payload};
    assign push_s     = in_valid && in_ready_r;
    assign pop_s      = out_valid_r && out_ready;

    // Occupancy, pointer and head-entry next-state computation
    always_comb begin
        occ_nxt_s   = occ_r;
        wr_nxt_s    = wr_ptr_r;
        rd_nxt_s    = rd_ptr_r;
        head_load_s = 1'b0;
        head_nxt_s  = head_r;

        if (push_s && !pop_s) begin
            occ_nxt_s = occ_r + CW'(1);
        end else if (!push_s && pop_s) begin
            occ_nxt_s = occ_r - CW'(1);
        end else begin
            occ_nxt_s = occ_r;
        end

        if (push_s) begin
            wr_nxt_s = wr_ptr_r + AW'(1);
        end else begin
            wr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_nxt_s = rd_ptr_r + AW'(1);
        end else begin
            rd_nxt_s = rd_ptr_r;
        end

        // The head register is reloaded whenever the head moves (pop) or the
        // FIFO was empty, provided something remains to present. If the new
        // head slot is the one being written this cycle (empty FIFO, or a
        // push+pop at occupancy 1) the data is taken straight from the input.
        head_load_s = (pop_s || (occ_r == CW'(0))) && (occ_nxt_s != CW'(0));
        if (push_s && (rd_nxt_s == wr_ptr_r)) begin
            head_nxt_s = in_entry_s;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Packet storage write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_entry_s;
        end
    end

    // Control state and registered output stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            occ_r       <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            head_r      <= '0;
        end else begin
            wr_ptr_r    <= wr_nxt_s;
            rd_ptr_r    <= rd_nxt_s;
            occ_r       <= occ_nxt_s;
            out_valid_r <= (occ_nxt_s != CW'(0));
            in_ready_r  <= (occ_nxt_s != CW'(DEPTH));
            if (head_load_s) begin
                head_r <= head_nxt_s;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign occupancy   = occ_r;
    assign out_id      = head_r[23:20];
    assign out_opcode  = head_r[19:16];
    assign out_payload = head_r[15:0];

`ifdef CPM_EGRESS_STATS_EN
    logic [31:0]   pkt_cnt_r;
    logic [CW-1:0] hwm_r;
    logic [15:0]   stall_cyc_r;

    // Statistics counters; a clear wins over any same-cycle update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt_r   <= 32'd0;
            hwm_r       <= '0;
            stall_cyc_r <= 16'd0;
        end else if (stats_clr) begin
            pkt_cnt_r   <= 32'd0;
            hwm_r       <= '0;
            stall_cyc_r <= 16'd0;
        end else begin
            if (pop_s) begin
                pkt_cnt_r <= pkt_cnt_r + 32'd1;
            end
            if (occ_nxt_s > hwm_r) begin
                hwm_r <= occ_nxt_s;
            end
            if (out_valid_r && !out_ready && (stall_cyc_r != 16'hFFFF)) begin
                stall_cyc_r <= stall_cyc_r + 16'd1;
            end
        end
    end

    assign stat_pkt_cnt   = pkt_cnt_r;
    assign stat_hwm       = hwm_r;
    assign stat_stall_cyc = stall_cyc_r;
`else
    logic unused_stats_clr_s;

    assign unused_stats_clr_s = stats_clr;
    assign stat_pkt_cnt       = 32'd0;
    assign stat_hwm           = '0;
    assign stat_stall_cyc     = 16'd0;
`endif

endmodule

// File: tb/tb_cpm_egress_fifo.sv
// ============================================================================
// tb_cpm_egress_fifo
// ----------------------------------------------------------------------------
// Self-checking bench for cpm_egress_fifo. A queue-based reference model holds
// the packets that should be stored; every cycle the DUT outputs are compared
// against it. Directed sequences cover latency, fill/drain, steady push+pop,
// stall-counter saturation and asynchronous reset; a randomized phase follows.
// ============================================================================
module tb_cpm_egress_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef CPM_EGRESS_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_id = 4'd0;
    logic [3:0]    in_opcode = 4'd0;
    logic [15:0]   in_payload = 16'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    out_id;
    logic [3:0]    out_opcode;
    logic [15:0]   out_payload;
    logic [CW-1:0] occupancy;
    logic          stats_clr = 1'b0;
    logic [31:0]   stat_pkt_cnt;
    logic [CW-1:0] stat_hwm;
    logic [15:0]   stat_stall_cyc;

    cpm_egress_fifo #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_id          (in_id),
        .in_opcode      (in_opcode),
        .in_payload     (in_payload),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_id         (out_id),
        .out_opcode     (out_opcode),
        .out_payload    (out_payload),
        .occupancy      (occupancy),
        .stats_clr      (stats_clr),
        .stat_pkt_cnt   (stat_pkt_cnt),
        .stat_hwm       (stat_hwm),
        .stat_stall_cyc (stat_stall_cyc)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [23:0] q[$];
    logic [23:0] delivered[$];
    int unsigned m_pkt;
    int unsigned m_hwm;
    int unsigned m_stall;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_cmp++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs_v, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        delivered.delete();
        m_pkt   = 0;
        m_hwm   = 0;
        m_stall = 0;
    endtask

    task automatic check_outputs();
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", {8'd0, out_id, out_opcode, out_payload}, {8'd0, q[0]});
        end
        chk("stat_pkt_cnt", stat_pkt_cnt, STATS_EN ? m_pkt : 32'd0);
        chk("stat_hwm", 32'(stat_hwm), STATS_EN ? m_hwm : 32'd0);
        chk("stat_stall_cyc", 32'(stat_stall_cyc), STATS_EN ? m_stall : 32'd0);
    endtask

    // One clock cycle: check outputs at the negedge, advance the model across
    // the rising edge using the inputs currently driven, return at the negedge.
    task automatic step();
        bit push_m;
        bit pop_m;
        bit stall_m;
        check_outputs();
        push_m  = in_valid && (q.size() != DEPTH);
        pop_m   = (q.size() != 0) && out_ready;
        stall_m = (q.size() != 0) && !out_ready;
        @(posedge clk);
        if (pop_m) begin
            delivered.push_back(q.pop_front());
        end
        if (push_m) begin
            q.push_back({in_id, in_opcode, in_payload});
        end
        if (stats_clr) begin
            m_pkt   = 0;
            m_hwm   = 0;
            m_stall = 0;
        end else begin
            if (pop_m) m_pkt = m_pkt + 1;
            if (q.size() > m_hwm) m_hwm = q.size();
            if (stall_m && m_stall != 32'hFFFF) m_stall = m_stall + 1;
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [3:0] id, input logic [3:0] op, input logic [15:0] pl);
        in_valid   = v;
        in_id      = id;
        in_opcode  = op;
        in_payload = pl;
    endtask

    task automatic drain();
        int budget;
        drive(1'b0, 4'd0, 4'd0, 16'd0);
        out_ready = 1'b1;
        budget = 0;
        while (q.size() != 0 && budget < 20) begin
            step();
            budget++;
        end
        chk("drain_done", 32'(q.size()), 32'd0);
        step();
    endtask

    initial begin
        int stall_len;
        int sent;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b1;
        step();

        // Single packet latency and field integrity
        out_ready = 1'b1;
        drive(1'b1, 4'd3, 4'd5, 16'hBEEF);
        step();
        drive(1'b0, 4'd0, 4'd0, 16'd0);
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("latency_payload", 32'(out_payload), 32'hBEEF);
        step();
        step();
        chk("single_delivered", 32'(delivered.size()), 32'd1);

        // Fill to full with the sink stalled, then release and drain in order
        delivered.delete();
        out_ready = 1'b0;
        sent = 1;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 4'd1, 4'd2, 16'(sent));
            if (q.size() != DEPTH) sent++;
            step();
        end
        chk("full_occ", 32'(occupancy), 32'(DEPTH));
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head", 32'(out_payload), 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 12 && delivered.size() < 5; c++) begin
            if (sent <= 5) drive(1'b1, 4'd1, 4'd2, 16'(sent));
            else           drive(1'b0, 4'd0, 4'd0, 16'd0);
            if (in_valid && q.size() != DEPTH) sent++;
            step();
        end
        chk("order_count", 32'(delivered.size()), 32'd5);
        for (int i = 0; i < 5 && i < delivered.size(); i++) begin
            chk("order_payload", 32'(delivered[i][15:0]), 32'(i + 1));
        end
        drain();

        // Steady push+pop at occupancy 1
        delivered.delete();
        out_ready = 1'b0;
        drive(1'b1, 4'd7, 4'd9, 16'd100);
        step();
        out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 4'd7, 4'd9, 16'(100 + i));
            step();
            chk("pp_occ", 32'(occupancy), 32'd1);
        end
        drain();
        for (int i = 0; i < 21 && i < delivered.size(); i++) begin
            chk("pp_seq", 32'(delivered[i][15:0]), 32'(100 + i));
        end

        // Long stall: saturating stall counter, then statistics clear
        stall_len = STATS_EN ? 70000 : 300;
        drive(1'b1, 4'hA, 4'hB, 16'h1234);
        out_ready = 1'b0;
        step();
        drive(1'b0, 4'd0, 4'd0, 16'd0);
        for (int i = 0; i < stall_len; i++) step();
        chk("stall_sat", 32'(stat_stall_cyc), STATS_EN ? 32'hFFFF : 32'd0);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        chk("clr_pkt", stat_pkt_cnt, 32'd0);
        chk("clr_stall", 32'(stat_stall_cyc), 32'd0);
        step();
        drain();

        // Asynchronous reset with three packets stored
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(i), 4'd1, 16'(16'h0500 + i));
            step();
        end
        drive(1'b0, 4'd0, 4'd0, 16'd0);
        chk("pre_reset_occ", 32'(occupancy), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        chk("async_occ", 32'(occupancy), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("no_stale", 32'(delivered.size()), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 16'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            stats_clr = ($urandom_range(0, 199) == 0);
            step();
        end
        stats_clr = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
